// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type and the fetch next-PC mode encoding.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    // Encodings 6 and 7 are unused and decode as SEQ.
    typedef enum logic [2:0] {
        SEQ = 3'd0,
        BR  = 3'd1,
        J   = 3'd2,
        JAL = 3'd3,
        JR  = 3'd4,
        RET = 3'd5
    } pcsrc_t;
endpackage

// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address predictor; a push when full overwrites the oldest entry.
module return_address_stack #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            push,
    input  logic            pop,
    input  logic            clr,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            do_pop;
    assign do_pop = pop && !empty;
    assign top    = mem[ptr];
    assign empty  = cnt == '0;
    assign full   = cnt == CW'(RAS_DEPTH);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            if (push) ptr <= ptr + 1'b1;
            else if (do_pop) ptr <= ptr - 1'b1;
            cnt <= clr ? '0 : push ? (full ? cnt : cnt + 1'b1) : do_pop ? cnt - 1'b1 : cnt;
        end
    end
    // Entries are only read while the count is non-zero, so they need no reset.
    always_ff @(posedge CLK) begin
        if (push) mem[ptr + 1'b1] <= push_data;
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC register with branch/jump target selection, redirect and RAS return prediction.
module fetch_pc_unit
    import cpu_types_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            stall,
    input  pcsrc_t          pcsrc,
    input  logic [15:0]     imm16,
    input  logic [25:0]     jaddr,
    input  logic [PC_W-1:0] regval,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            ras_clr,
    output logic [PC_W-1:0] imemaddr,
    output logic [PC_W-1:0] npc,
    output logic            ras_empty,
    output logic            ras_full
);
    logic [PC_W-1:0] pc, next_pc, br_tgt, j_tgt, ras_top;
    logic            upd, push, pop;
    assign imemaddr = pc;
    assign npc      = pc + PC_W'(4);
    assign br_tgt   = npc + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    assign j_tgt    = (npc & ~PC_W'(28'hFFF_FFFF)) | PC_W'({jaddr, 2'b00});
    // Redirect outranks a normal fetch step and leaves the RAS alone.
    assign upd  = ihit && !stall && !redirect_en;
    assign push = upd && pcsrc == JAL;
    assign pop  = upd && pcsrc == RET && !ras_empty;
    always_comb begin
        next_pc = redirect_en                 ? redirect_pc :
                  pcsrc == BR                 ? br_tgt :
                  (pcsrc == J || pcsrc == JAL) ? j_tgt :
                  pcsrc == JR                 ? regval :
                  pcsrc == RET                ? (ras_empty ? regval : ras_top) :
                                                npc;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pc <= RESET_PC;
        else if (redirect_en || upd) pc <= next_pc;
    end
    return_address_stack #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (push),
        .pop       (pop),
        .clr       (ras_clr),
        .push_data (npc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for fetch_pc_unit against a queue-based PC/RAS reference model.
module tb_fetch_pc_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0, stall = 1'b0, redirect_en = 1'b0, ras_clr = 1'b0;
    pcsrc_t      pcsrc = SEQ;
    logic [15:0] imm16 = '0;
    logic [25:0] jaddr = '0;
    logic [31:0] regval = '0, redirect_pc = '0;
    logic [31:0] imemaddr, npc;
    logic        ras_empty, ras_full;

    fetch_pc_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .pcsrc(pcsrc),
        .imm16(imm16), .jaddr(jaddr), .regval(regval), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .ras_clr(ras_clr), .imemaddr(imemaddr), .npc(npc),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic        emp;
        logic        ful;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ras_q[$];
    logic [31:0] m_pc = '0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the RAS is a plain list of return links, newest at the back, at most 4 long.
    function automatic void model_step();
        logic [31:0] n;
        n = m_pc + 32'd4;
        if (redirect_en) m_pc = redirect_pc;
        else if (ihit && !stall) begin
            case (pcsrc)
                BR:  m_pc = n + ({{16{imm16[15]}}, imm16} << 2);
                J:   m_pc = {n[31:28], jaddr, 2'b00};
                JAL: begin
                    m_pc = {n[31:28], jaddr, 2'b00};
                    ras_q.push_back(n);
                    if (ras_q.size() > 4) void'(ras_q.pop_front());
                end
                JR:  m_pc = regval;
                RET: if (ras_q.size() > 0) m_pc = ras_q.pop_back(); else m_pc = regval;
                default: m_pc = n;
            endcase
        end
        if (ras_clr) ras_q.delete();
        sb.push_back('{m_pc, ras_q.size() == 0, ras_q.size() == 4});
    endfunction

    task automatic apply(input logic ih, input logic st, input pcsrc_t src, input logic [15:0] im,
                         input logic [25:0] ja, input logic [31:0] rv, input logic re,
                         input logic [31:0] rp, input logic cl);
        @(negedge CLK);
        ihit = ih; stall = st; pcsrc = src; imm16 = im; jaddr = ja;
        regval = rv; redirect_en = re; redirect_pc = rp; ras_clr = cl;
        model_step();
    endtask

    task automatic sync();
        @(posedge CLK);
        #2;
    endtask

    task automatic step(input pcsrc_t src, input logic [25:0] ja, input logic [31:0] rv);
        apply(1'b1, 1'b0, src, 16'h0, ja, rv, 1'b0, 32'h0, 1'b0);
        sync();
    endtask

    task automatic redir(input logic [31:0] rp);
        apply(1'b0, 1'b0, SEQ, 16'h0, 26'h0, 32'h0, 1'b1, rp, 1'b0);
        sync();
    endtask

    // Monitor: every clock edge presents a new PC, checked against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", imemaddr, e.pc);
                chk("sb_npc", npc, e.pc + 32'd4);
                chk("sb_ras_empty", {31'b0, ras_empty}, {31'b0, e.emp});
                chk("sb_ras_full", {31'b0, ras_full}, {31'b0, e.ful});
            end
        end
    end

    initial begin
        logic [31:0] lk [5];
        lk = '{32'h54, 32'h404, 32'h804, 32'hC04, 32'h1004};
        #2;
        chk("rst_pc", imemaddr, 32'h0);
        chk("rst_npc", npc, 32'h4);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_full", {31'b0, ras_full}, 32'h0);
        #10 nRST = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            step(SEQ, 26'h0, 32'h0);
            chk("seq_pc", imemaddr, 32'(4 * i));
        end

        redir(32'h100);
        apply(1'b1, 1'b0, BR, 16'hFFFE, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        sync();
        chk("br_back", imemaddr, 32'hFC);
        redir(32'h100);
        step(J, 26'h40, 32'h0);
        chk("j_tgt", imemaddr, 32'h100);

        apply(1'b1, 1'b1, SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        sync();
        chk("stall_hold", imemaddr, 32'h100);
        step(JAL, 26'h80, 32'h0);
        chk("jal_tgt", imemaddr, 32'h200);
        apply(1'b1, 1'b1, JAL, 16'h0, 26'h0, 32'h0, 1'b1, 32'h2000, 1'b0);
        sync();
        chk("redirect_pc", imemaddr, 32'h2000);
        chk("redirect_ras", {31'b0, ras_empty}, 32'h0);
        apply(1'b1, 1'b0, SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        sync();
        chk("clr_empty", {31'b0, ras_empty}, 32'h1);

        redir(32'h10);
        step(JAL, 26'h100, 32'h0);
        redir(32'h200);
        step(JAL, 26'h100, 32'h0);
        redir(32'h300);
        step(JAL, 26'h100, 32'h0);
        step(RET, 26'h0, 32'h999C);
        chk("ret1", imemaddr, 32'h304);
        step(RET, 26'h0, 32'h999C);
        chk("ret2", imemaddr, 32'h204);
        step(RET, 26'h0, 32'h999C);
        chk("ret3", imemaddr, 32'h14);
        step(RET, 26'h0, 32'h50);
        chk("ret_fallback", imemaddr, 32'h50);

        for (int k = 1; k <= 5; k++) step(JAL, 26'(k * 256), 32'h0);
        chk("ovf_full", {31'b0, ras_full}, 32'h1);
        for (int k = 4; k >= 1; k--) begin
            step(RET, 26'h0, 32'h0);
            chk("ovf_ret", imemaddr, lk[k]);
        end
        chk("ovf_empty", {31'b0, ras_empty}, 32'h1);

        step(JAL, 26'h10, 32'h0);
        apply(1'b1, 1'b0, JAL, 16'h0, 26'h20, 32'h0, 1'b0, 32'h0, 1'b1);
        sync();
        chk("clr_jal_empty", {31'b0, ras_empty}, 32'h1);

        step(JAL, 26'h30, 32'h0);
        chk("pre_rst_empty", {31'b0, ras_empty}, 32'h0);
        nRST = 1'b0;
        #1;
        chk("async_rst_pc", imemaddr, 32'h0);
        chk("async_rst_empty", {31'b0, ras_empty}, 32'h1);
        #1 nRST = 1'b1;
        m_pc = '0;
        ras_q.delete();

        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
                  pcsrc_t'(3'($urandom_range(0, 7))), 16'($urandom),
                  26'($urandom), {$urandom, 2'b00} >> 2 << 2,
                  $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 19) == 0);
        end
        apply(1'b0, 1'b0, SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge CLK);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program-counter unit for the fetch stage. It holds the architectural fetch PC and supplies it to instruction memory. On each accepted fetch it computes the next PC from sequential, branch, jump, jump-and-link, register-jump and return modes. Over the single-PC predecessor it adds a stall qualifier, a highest-priority redirect from later stages, a configurable reset vector and a small circular return-address stack (RAS) that predicts `jr $31` targets.

## Interface
- `PC_W`, 32: PC width in bits; must be ≥ 28.
- `RESET_PC`, 0: PC value loaded on reset; word aligned.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥ 2.
- Clock and reset: one clock; reset is asynchronous and active-low (`CLK`, `nRST`).
- `CLK`  in  1  clock.
- `nRST`  in  1  asynchronous active-low reset.
- `ihit`  in  1  instruction memory returned the current fetch.
- `stall`  in  1  hazard hold; blocks the PC update even when `ihit`=1.
- `pcsrc`  in  3  `pcsrc_t` next-PC mode: SEQ, BR, J, JAL, JR, RET.
- `imm16`  in  16  branch offset in words.
- `jaddr`  in  26  jump target field.
- `regval`  in  PC_W  register operand for JR, and the RET fallback.
- `redirect_en`  in  1  later-stage correction (mispredict/flush).
- `redirect_pc`  in  PC_W  corrected PC.
- `ras_clr`  in  1  empty the RAS.
- `imemaddr`  out  PC_W  current PC.
- `npc`  out  PC_W  PC+4, used as the link value.
- `ras_empty`  out  1  RAS count is 0.
- `ras_full`  out  1  RAS count equals RAS_DEPTH.

## Operation
- `npc` = PC + 4, modulo 2^PC_W.
- Next PC by `pcsrc`:
  - SEQ: `npc`.
  - BR: `npc` + (sign-extended `imm16` << 2), modulo 2^PC_W.
  - J: {`npc`[PC_W-1:28], `jaddr`, 2'b00}.
  - JAL: same target as J, and pushes `npc` onto the RAS.
  - JR: `regval`.
  - RET: RAS top, which is popped, if the RAS is non-empty; otherwise `regval` with no pop.
- Update condition, in priority order:
  1. `redirect_en`: PC ← `redirect_pc`. Applies regardless of `ihit` and `stall`. The RAS does not push or pop.
  2. `ihit` && !`stall`: PC ← next PC, and the RAS action for the current `pcsrc` is taken.
  3. Otherwise PC holds and the RAS is unchanged.
- RAS storage:
  - Circular buffer with a top pointer and a count that saturates at RAS_DEPTH.
  - A push when full overwrites the oldest entry: the pointer wraps and the count stays at RAS_DEPTH.
  - A pop when empty does not occur, because RET falls back to `regval`.
- `ras_clr` zeroes the count on the next edge and has priority over a same-cycle push.
- Undefined `pcsrc` encodings behave as SEQ.

## Timing
- Reset: PC = RESET_PC, RAS count = 0, `ras_empty`=1, `ras_full`=0, `imemaddr` = RESET_PC, `npc` = RESET_PC+4.
- An asserted `nRST` mid-operation discards any in-flight update immediately.
- PC is a register and `imemaddr` is driven directly from it. A qualifying edge makes the new PC visible one cycle later.
- Next-PC selection is combinational from the current inputs; latency from qualifying edge to new `imemaddr` is 1 cycle.
- RAS read is combinational from the top entry, so RET target selection has zero added latency.
- Push and pop commit on the same edge as the PC update.
- `ras_empty` and `ras_full` reflect the registered count.

## Structure
- `pcsrc_t` enum goes in `cpu_types_pkg`, alongside `word_t`.
- Sub-module `return_address_stack`:
  - Parameters: PC_W, RAS_DEPTH.
  - Ports: push, pop, clr, push_data, top, empty, full.
- Top level holds the PC register, target arithmetic and priority mux.

## Test plan
- Reset and stepping: PC=0 out of reset; `ihit`=1, SEQ for 3 cycles → `imemaddr` 0x0, 0x4, 0x8, 0xC.
- Branch and jump targets:
  - PC=0x100, BR, `imm16`=0xFFFE → 0xFC.
  - PC=0x100, J, `jaddr`=0x40 → 0x100.
- Stall and redirect:
  - `ihit`=1, `stall`=1 → PC holds.
  - Same cycle with `redirect_en`=1, `redirect_pc`=0x2000 → 0x2000, RAS count unchanged.
- Nested calls and returns: JAL at 0x10, 0x200, 0x300 → 3 RET pops predict 0x304, 0x204, 0x14; a 4th RET with `regval`=0x50 → 0x50.
- RAS overflow: RAS_DEPTH=4, 5 JALs pushing links L1..L5 → `ras_full`=1; 4 RETs → L5, L4, L3, L2, then `ras_empty`=1.
- Mid-operation reset: `nRST` pulsed mid-sequence → PC = RESET_PC and `ras_empty`=1 asynchronously. Also `ras_clr` together with JAL → count 0.
